// File: rtl/inst_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Instruction fetch/decode stage. Owns the PC, issues word
//               requests over a req/ack handshake, latches the returned
//               instruction and splits it into register-fetch fields.
//               Handles stall and branch redirects, including redirects that
//               arrive while a memory request is still outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch #(
  parameter int               REG_INDEX_BIT_WIDTH = 4,
  parameter int               DBITS               = 32,
  parameter logic [DBITS-1:0] RESET_PC            = '0
) (
  input  logic                           clk,
  input  logic                           res,
  input  logic                           stall,
  input  logic                           brTaken,
  input  logic [DBITS-1:0]               brTarget,
  output logic                           imemReq,
  output logic [DBITS-1:0]               imemAddr,
  input  logic                           imemAck,
  input  logic [31:0]                    imemData,
  output logic                           instValid,
  output logic [DBITS-1:0]               pc,
  output logic [DBITS-1:0]               pcPlus4,
  output logic [3:0]                     opcode,
  output logic [REG_INDEX_BIT_WIDTH-1:0] rd,
  output logic [REG_INDEX_BIT_WIDTH-1:0] rs1,
  output logic [REG_INDEX_BIT_WIDTH-1:0] rs2,
  output logic [15:0]                    imm16
);

  localparam logic [1:0]       c_st_fetch  = 2'd0;
  localparam logic [1:0]       c_st_valid  = 2'd1;
  localparam logic [1:0]       c_st_squash = 2'd2;
  localparam logic [DBITS-1:0] c_pc_step   = DBITS'(4);
  localparam logic [DBITS-1:0] c_word_mask = {{(DBITS-2){1'b1}}, 2'b00};

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [DBITS-1:0] r_addr;
  logic [DBITS-1:0] r_tgt;
  logic [31:0]      r_inst;
  logic [DBITS-1:0] w_br_tgt;

  // Redirect targets are always word aligned; the low two bits are dropped.
  assign w_br_tgt = brTarget & c_word_mask;

  // State register.
  always_ff @(posedge clk) begin
    if (res) r_state <= c_st_fetch;
    else     r_state <= w_state_nxt;
  end

  // Next-state selection; a redirect without ack in FETCH must ride out the
  // outstanding request in SQUASH so the handshake is never abandoned.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_fetch: begin
        if (imemAck)      w_state_nxt = brTaken ? c_st_fetch : c_st_valid;
        else if (brTaken) w_state_nxt = c_st_squash;
      end
      c_st_squash: begin
        if (imemAck) w_state_nxt = c_st_fetch;
      end
      c_st_valid: begin
        if (brTaken || !stall) w_state_nxt = c_st_fetch;
      end
      default: w_state_nxt = c_st_fetch;
    endcase
  end

  // State-decoded outputs; the request is masked while reset is asserted.
  always_comb begin
    imemReq   = 1'b0;
    instValid = 1'b0;
    case (r_state)
      c_st_fetch, c_st_squash: imemReq   = !res;
      c_st_valid:              instValid = 1'b1;
      default: begin
        imemReq   = 1'b0;
        instValid = 1'b0;
      end
    endcase
  end

  // Address, instruction and pending-target registers.
  always_ff @(posedge clk) begin
    if (res) begin
      r_addr <= RESET_PC;
      r_inst <= '0;
      r_tgt  <= '0;
    end else begin
      case (r_state)
        c_st_fetch: begin
          if (imemAck && !brTaken) r_inst <= imemData;
          if (imemAck && brTaken)  r_addr <= w_br_tgt;
          if (!imemAck && brTaken) r_tgt  <= w_br_tgt;
        end
        c_st_squash: begin
          // The newest redirect wins, even in the cycle the old ack lands.
          if (brTaken) r_tgt  <= w_br_tgt;
          if (imemAck) r_addr <= brTaken ? w_br_tgt : r_tgt;
        end
        c_st_valid: begin
          if (brTaken)     r_addr <= w_br_tgt;
          else if (!stall) r_addr <= r_addr + c_pc_step;
        end
        default: begin
          r_addr <= r_addr;
        end
      endcase
    end
  end

  assign imemAddr = r_addr;
  assign pc       = r_addr;
  assign pcPlus4  = r_addr + c_pc_step;
  assign opcode   = r_inst[31:28];
  assign rd       = r_inst[24 +: REG_INDEX_BIT_WIDTH];
  assign rs1      = r_inst[20 +: REG_INDEX_BIT_WIDTH];
  assign rs2      = r_inst[16 +: REG_INDEX_BIT_WIDTH];
  assign imm16    = r_inst[15:0];

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch
// Description : Self-checking bench for inst_fetch: directed scenarios plus
//               a randomized run against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

  logic        clk;
  logic        res;
  logic        stall;
  logic        brTaken;
  logic [31:0] brTarget;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic        instValid;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [3:0]  opcode;
  logic [3:0]  rd;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [15:0] imm16;

  int n_checks = 0;
  int n_fail   = 0;

  inst_fetch #(
    .REG_INDEX_BIT_WIDTH(4),
    .DBITS(32),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .res(res), .stall(stall), .brTaken(brTaken), .brTarget(brTarget),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
    .instValid(instValid), .pc(pc), .pcPlus4(pcPlus4), .opcode(opcode),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm16(imm16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the pipe either holds a valid instruction or has a
  // request outstanding; a redirect seen while waiting is remembered and the
  // returning word is thrown away.
  logic [31:0] m_addr  = 32'h0;
  logic [31:0] m_inst  = 32'h0;
  logic        m_valid = 1'b0;
  logic        m_redir = 1'b0;
  logic [31:0] m_tgt   = 32'h0;

  function automatic void model_step();
    logic [31:0] t;
    t = brTarget & 32'hFFFF_FFFC;
    if (res) begin
      m_addr = 32'h0; m_inst = 32'h0; m_valid = 1'b0; m_redir = 1'b0; m_tgt = 32'h0;
    end else if (m_valid) begin
      if (brTaken) begin
        m_addr = t; m_valid = 1'b0;
      end else if (!stall) begin
        m_addr = m_addr + 32'd4; m_valid = 1'b0;
      end
    end else if (imemAck) begin
      if (brTaken)      m_addr = t;
      else if (m_redir) m_addr = m_tgt;
      else begin
        m_inst = imemData; m_valid = 1'b1;
      end
      m_redir = 1'b0;
    end else if (brTaken) begin
      m_tgt = t; m_redir = 1'b1;
    end
  endfunction

  // Advance one clock: the model sees exactly the inputs the DUT sampled.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    res = 1'b0; stall = 1'b0; brTaken = 1'b0; brTarget = 32'h0;
    imemAck = 1'b0; imemData = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    res = 1'b1; imemAck = 1'b1; imemData = 32'hFFFF_FFFF;
    tick();
    res = 1'b1; imemAck = 1'b1;
    #1;
    n_checks++;
    if ({imemReq, instValid} !== 2'b00) begin
      n_fail++; $display("FAIL reset_cycle_outputs: req/valid got %b want 00", {imemReq, instValid});
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if ({imemReq, instValid, imemAddr} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL reset_first_req: req=%b valid=%b addr=%h want 1 0 00000000", imemReq, instValid, imemAddr);
    end
    n_checks++;
    if ({opcode, rd, rs1, rs2, imm16} !== 32'h0) begin
      n_fail++; $display("FAIL reset_fields: got %h want 00000000", {opcode, rd, rs1, rs2, imm16});
    end
  endtask

  task automatic test_zero_wait();
    imemAck = 1'b1; imemData = 32'h1234_ABCD;
    #1;
    n_checks++;
    if (imemAddr !== 32'h0) begin
      n_fail++; $display("FAIL zw_addr0: got %h want 00000000", imemAddr);
    end
    tick();
    imemAck = 1'b0;
    #1;
    n_checks++;
    if ({instValid, opcode, rd, rs1, rs2, imm16, pcPlus4} !== {1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 16'hABCD, 32'h4}) begin
      n_fail++; $display("FAIL zw_decode: valid=%b fields=%h pcPlus4=%h want 1 1234abcd 00000004",
                         instValid, {opcode, rd, rs1, rs2, imm16}, pcPlus4);
    end
    tick();
    #1;
    n_checks++;
    if ({imemReq, imemAddr} !== {1'b1, 32'h4}) begin
      n_fail++; $display("FAIL zw_next_addr: req=%b addr=%h want 1 00000004", imemReq, imemAddr);
    end
    imemAck = 1'b1; imemData = 32'h5555_0004;
    tick();
    imemAck = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    imemAck = 1'b1; imemData = 32'h9ABC_0008;
    tick();
    imemAck = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({instValid, imemReq, pc, opcode, rd, rs1, rs2, imm16} !== {1'b1, 1'b0, 32'h8, 32'h9ABC_0008}) begin
        n_fail++; $display("FAIL stall_hold[%0d]: valid=%b req=%b pc=%h fields=%h want 1 0 00000008 9abc0008",
                           i, instValid, imemReq, pc, {opcode, rd, rs1, rs2, imm16});
      end
      tick();
    end
    stall = 1'b0;
    tick();
    #1;
    n_checks++;
    if ({imemReq, imemAddr} !== {1'b1, 32'hC}) begin
      n_fail++; $display("FAIL stall_release: req=%b addr=%h want 1 0000000c", imemReq, imemAddr);
    end
    imemAck = 1'b1; imemData = 32'h7777_000C;
    tick();
    imemAck = 1'b0;
  endtask

  task automatic test_branch_over_stall();
    stall = 1'b1; brTaken = 1'b1; brTarget = 32'h103;
    tick();
    stall = 1'b0; brTaken = 1'b0;
    #1;
    n_checks++;
    if ({instValid, imemReq, imemAddr} !== {1'b0, 1'b1, 32'h100}) begin
      n_fail++; $display("FAIL branch_over_stall: valid=%b req=%b addr=%h want 0 1 00000100", instValid, imemReq, imemAddr);
    end
  endtask

  task automatic test_squash();
    imemAck = 1'b1; brTaken = 1'b1; brTarget = 32'h10;
    tick();
    imemAck = 1'b0;
    for (int i = 0; i < 4; i++) begin
      brTaken  = (i < 2);
      brTarget = (i == 0) ? 32'h40 : 32'h80;
      imemAck  = (i == 3);
      imemData = 32'hBAD0_0010;
      #1;
      n_checks++;
      if ({imemReq, imemAddr, instValid} !== {1'b1, 32'h10, 1'b0}) begin
        n_fail++; $display("FAIL squash_hold[%0d]: req=%b addr=%h valid=%b want 1 00000010 0", i, imemReq, imemAddr, instValid);
      end
      tick();
    end
    idle_inputs();
    #1;
    n_checks++;
    if ({imemReq, imemAddr, instValid} !== {1'b1, 32'h80, 1'b0}) begin
      n_fail++; $display("FAIL squash_target: req=%b addr=%h valid=%b want 1 00000080 0", imemReq, imemAddr, instValid);
    end
  endtask

  task automatic test_wrap();
    imemAck = 1'b1; brTaken = 1'b1; brTarget = 32'hFFFF_FFFF;
    tick();
    brTaken = 1'b0; imemData = 32'hCAFE_1234;
    #1;
    n_checks++;
    if (imemAddr !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_target: got %h want fffffffc", imemAddr);
    end
    tick();
    imemAck = 1'b0;
    #1;
    n_checks++;
    if ({instValid, pc, pcPlus4} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
      n_fail++; $display("FAIL wrap_pcplus4: valid=%b pc=%h pcPlus4=%h want 1 fffffffc 00000000", instValid, pc, pcPlus4);
    end
    tick();
    #1;
    n_checks++;
    if ({imemReq, imemAddr} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL wrap_advance: req=%b addr=%h want 1 00000000", imemReq, imemAddr);
    end
  endtask

  task automatic test_reset_mid_request();
    imemAck = 1'b1; brTaken = 1'b1; brTarget = 32'h20;
    tick();
    brTaken = 1'b0; res = 1'b1; imemAck = 1'b1; imemData = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if ({imemReq, imemAddr} !== {1'b0, 32'h20}) begin
      n_fail++; $display("FAIL midreset_req: req=%b addr=%h want 0 00000020", imemReq, imemAddr);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if ({instValid, imemAddr, opcode, rd, rs1, rs2, imm16} !== {1'b0, 32'h0, 32'h0}) begin
      n_fail++; $display("FAIL midreset_state: valid=%b addr=%h fields=%h want 0 00000000 00000000",
                         instValid, imemAddr, {opcode, rd, rs1, rs2, imm16});
    end
  endtask

  task automatic test_random();
    int wait_cnt;
    int delay;
    logic exp_req;
    wait_cnt = 0;
    delay    = 0;
    idle_inputs();
    res = 1'b1;
    tick();
    for (int cyc = 0; cyc < 600; cyc++) begin
      res      = ($urandom_range(0, 59) == 0);
      stall    = $urandom_range(0, 1) == 1;
      brTaken  = ($urandom_range(0, 5) == 0);
      brTarget = $urandom;
      imemData = $urandom;
      exp_req  = !m_valid && !res;
      imemAck  = 1'b0;
      if (res) begin
        imemAck  = $urandom_range(0, 1) == 1;
        wait_cnt = 0;
      end else if (exp_req) begin
        if (wait_cnt >= delay) begin
          imemAck  = 1'b1;
          wait_cnt = 0;
          delay    = $urandom_range(0, 3);
        end else begin
          wait_cnt++;
        end
      end
      #1;
      n_checks++;
      if ({imemReq, imemAddr, instValid, pc, pcPlus4, opcode, rd, rs1, rs2, imm16} !==
          {exp_req, m_addr, m_valid, m_addr, m_addr + 32'd4, m_inst}) begin
        n_fail++;
        $display("FAIL random[%0d]: req=%b addr=%h valid=%b pc4=%h inst=%h want %b %h %b %h %h",
                 cyc, imemReq, imemAddr, instValid, pcPlus4, {opcode, rd, rs1, rs2, imm16},
                 exp_req, m_addr, m_valid, m_addr + 32'd4, m_inst);
      end
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_zero_wait();
    test_stall();
    test_branch_over_stall();
    test_squash();
    test_wrap();
    test_reset_mid_request();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
